// File: rtl/rw_memory.sv
// rw_memory: word-organised data memory with synchronous write and registered read
//   Ports:
//     i_clk         clock; all state updates on the rising edge
//     i_reset       synchronous active-low reset; clears read data and every word
//     i_address     32-bit byte address; word index = address[ADDR_BITS+1:2]
//     i_write_data  word stored when i_mem_store is high
//     i_mem_store   write enable, one word per asserted edge
//     i_mem_load    read enable; result appears on o_read_data after the edge
//     o_read_data   registered read result; holds until the next load
module rw_memory #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [31:0]           i_address,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   input  logic                  i_mem_store,
   input  logic                  i_mem_load,
   output logic [DATA_WIDTH-1:0] o_read_data
);
   localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] r_read_data;
   logic [ADDR_BITS-1:0]  w_idx;
   logic                  w_in_range;
   assign w_idx       = i_address[ADDR_BITS+1:2];
   // any address bit above the word index makes the access out of range (no wrap)
   assign w_in_range  = ~|i_address[31:ADDR_BITS+2];
   assign o_read_data = r_read_data;
   // read samples the old word before the write lands, giving read-before-write
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_read_data <= '0;
         r_mem       <= '{default: '0};
      end else begin
         if (i_mem_store && w_in_range) r_mem[w_idx] <= i_write_data;
         if (i_mem_load) r_read_data <= w_in_range ? r_mem[w_idx] : '0;
      end
   end
endmodule

// File: tb/tb_rw_memory.sv
// tb_rw_memory: scoreboard bench for rw_memory with directed and random accesses
module tb_rw_memory;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic        mem_store = 1'b0;
   logic        mem_load = 1'b0;
   logic [31:0] read_data;
   logic [31:0] exp_q [$];
   logic [31:0] model [256];
   logic [31:0] last_rd = '0;
   logic [31:0] e;
   int          n_cmp = 0;
   int          n_err = 0;

   rw_memory dut (
      .i_clk(clk), .i_reset(reset), .i_address(address), .i_write_data(write_data),
      .i_mem_store(mem_store), .i_mem_load(mem_load), .o_read_data(read_data)
   );

   always #5 clk = ~clk;

   task automatic cyc(input bit rst_n, input bit st, input bit ld, input logic [31:0] a,
                      input logic [31:0] d);
      int idx;
      bit inr;
      @(negedge clk);
      reset = rst_n; mem_store = st; mem_load = ld; address = a; write_data = d;
      inr = (a < 32'd1024);
      idx = int'(a / 4) % 256;
      if (!rst_n) begin
         foreach (model[i]) model[i] = '0;
         last_rd = '0;
      end else begin
         if (ld) last_rd = inr ? model[idx] : 32'h0;
         if (st && inr) model[idx] = d;
      end
      exp_q.push_back(last_rd);
   endtask

   always @(posedge clk) begin
      if (exp_q.size() != 0) begin
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (read_data !== e) begin
            n_err++;
            $display("FAIL rd_check vec %0d at %0t: got %h expected %h", n_cmp, $time, read_data, e);
         end
      end
   end

   initial begin
      logic [31:0] a;
      cyc(0, 0, 0, 32'h0, 32'h0);
      cyc(1, 0, 1, 32'h000, 32'h0);
      cyc(1, 0, 1, 32'h3FC, 32'h0);
      cyc(1, 1, 0, 32'h004, 32'hDEADBEEF);
      cyc(1, 0, 1, 32'h004, 32'h0);
      cyc(1, 0, 0, 32'h004, 32'h0);
      cyc(1, 0, 0, 32'h010, 32'h0);
      cyc(1, 1, 0, 32'h008, 32'h12345678);
      cyc(1, 0, 1, 32'h008, 32'h0);
      cyc(1, 0, 1, 32'h004, 32'h0);
      cyc(0, 1, 1, 32'h004, 32'h55555555);
      cyc(1, 0, 1, 32'h004, 32'h0);
      cyc(1, 0, 1, 32'h008, 32'h0);
      cyc(1, 1, 1, 32'h00C, 32'hAAAA5555);
      cyc(1, 0, 1, 32'h00C, 32'h0);
      cyc(1, 0, 1, 32'h00E, 32'h0);
      cyc(1, 1, 0, 32'h400, 32'hCAFEF00D);
      cyc(1, 0, 1, 32'h400, 32'h0);
      cyc(1, 0, 1, 32'h000, 32'h0);
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 4) == 0)
            a = (32'h400 << $urandom_range(0, 21)) | 32'($urandom_range(0, 1023));
         else if ($urandom_range(0, 3) == 0)
            a = 32'($urandom_range(0, 1023));
         else
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         cyc($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, a, $urandom);
      end
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
